fence_t_sequencer: RTL and testbench
====================================

Name: fence_t_sequencer

Overview:
Parametrised temporal-fence (fence.t) sequencer. It generalises the single-cache flush/microreset FSM to the following:
- N flush channels, each with its own req/ack handshake and busy input.
- M microreset domains, released in a staggered order.
- Configurable reset length and init-hold length.
- Optional time-interrupt padding.

It sits beside the flush controller. It halts commit, flushes all caches, waits for quiescence and padding, pulses the microresets, and provides the restart PC.

Parameters:
NUM_FLUSH, 2, number of flush req/ack/busy channels (>=1)
NUM_DOMAINS, 2, number of microreset domains (>=1)
RST_CYCLES, 16, cycles all domains are held in reset (>=1)
INIT_HOLD, 3, cycles cache_init_no stays high after the last RST cycle (>=1)
PAD_W, 32, width of pad counter
VLEN, 64, virtual address width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
fence_t_i  in  1  fence.t committed (single-cycle pulse)
pc_commit_i  in  VLEN  PC of committing instruction
boot_addr_i  in  VLEN  restart address after power-on reset
rst_addr_o  out  VLEN  address to fetch from after microreset
pad_en_i  in  1  1: honour padding; 0: ignore pad counter
pad_cycles_i  in  PAD_W  pad counter load value
time_irq_i  in  1  timer interrupt level
flush_req_o  out  NUM_FLUSH  per-channel flush request
flush_ack_i  in  NUM_FLUSH  per-channel flush acknowledge
busy_i  in  NUM_FLUSH  per-channel outstanding-transaction indicator
halt_o  out  1  halt commit stage
rst_uarch_no  out  NUM_DOMAINS  per-domain active-low microreset
cache_init_no  out  1  suppress cache initialisation
done_o  out  1  one-cycle pulse when the sequence completes

Behaviour:
- Reset is asynchronous. It is decided as: reset rst_ni, asynchronous, active-low; clock clk_i.
- Reset values:
  - state=IDLE; flush_req_o=0; ack_seen=0; rst_cnt=0; pad_cnt=0; init_cnt=0; time_irq_q=0; done_o=0.
  - rst_addr_o=boot_addr_i.
  - rst_uarch_no=all 1; cache_init_no=0; halt_o=0.
- Reset asserted mid-sequence aborts immediately to the reset values. No partial state survives.
- FSM states: IDLE, FLUSH, WAIT, RST, RELEASE.
- IDLE, on fence_t_i=1:
  - Go to FLUSH.
  - rst_addr_q <= pc_commit_i + 4 (modulo 2^VLEN).
  - flush_req_o <= all 1, registered, so visible the next cycle.
  - ack_seen <= 0.
  - fence_t_i outside IDLE is ignored; rst_addr_q is unchanged.
- FLUSH:
  - Channel i: while flush_req_o[i]=1 and flush_ack_i[i]=1, set ack_seen[i] and clear flush_req_o[i] the next cycle.
  - An ack on a channel with req=0 is ignored.
  - Go to WAIT when (ack_seen | (flush_ack_i & flush_req_o)) is all 1. Simultaneous acks on all channels in one cycle are allowed.
- WAIT: go to RST when busy_i==0 and (pad_en_i==0 or pad_cnt==0), evaluated in the same cycle.
- RST:
  - All rst_uarch_no=0.
  - rst_cnt increments from 0; when rst_cnt==RST_CYCLES-1, clear rst_cnt and go to RELEASE.
  - Every RST cycle reloads init_cnt=INIT_HOLD.
- RELEASE:
  - Lasts NUM_DOMAINS cycles, with rst_cnt counting 0..NUM_DOMAINS-1.
  - In cycle j, rst_uarch_no[k]=1 for k<=j and 0 for k>j (domain 0 first, one per cycle).
  - After cycle NUM_DOMAINS-1: rst_cnt=0, go to IDLE, done_o=1 for one cycle (registered).
- halt_o = (state!=IDLE), combinational.
- cache_init_no = (init_cnt!=0). init_cnt decrements by 1 per cycle outside RST and saturates at 0.
- Pad counter:
  - time_irq_q registers time_irq_i.
  - Rising edge (time_irq_i & ~time_irq_q) loads pad_cycles_i. This applies in any state.
  - Otherwise pad_cnt decrements when nonzero, and stops at 0 (no wrap).
  - Load has priority over decrement.
  - A load of 0 leaves the counter idle.
- Total sequence length with no flush wait and no padding: 1 (FLUSH, if acks return in its first cycle) + 1 (WAIT) + RST_CYCLES + NUM_DOMAINS.

Test Plan:
1. Defaults, busy_i=0, pad_en_i=0, pc_commit_i=0x8000_0100, fence_t_i pulse:
   - flush_req_o=2'b11 the next cycle; ack ch0 at cycle 3, ch1 at cycle 5.
   - Expect req[0] low from cycle 4 and req[1] low from cycle 6.
   - Expect rst_uarch_no=2'b00 for 16 cycles, then 2'b01, then 2'b11.
   - Expect done_o pulse; rst_addr_o=0x8000_0104; halt_o high throughout.
2. Both acks in the same cycle as the first request cycle:
   - FLUSH lasts exactly 1 cycle; WAIT lasts 1 cycle.
3. pad_en_i=1, pad_cycles_i=10, time_irq rising edge 2 cycles before WAIT:
   - RST is entered only once pad_cnt reaches 0 (8 WAIT cycles).
   - Repeat with pad_en_i=0: RST is entered immediately.
4. busy_i[1]=1 held for 20 cycles in WAIT:
   - FSM stays in WAIT until busy_i drops; rst_uarch_no stays all 1.
5. Spurious flush_ack_i in IDLE, and a second fence_t_i during RST:
   - No state change; rst_addr_o is not overwritten.
6. rst_ni asserted in RST cycle 5:
   - Immediately rst_uarch_no=all 1, halt_o=0, flush_req_o=0, rst_addr_o=boot_addr_i.
   - cache_init_no=0 after reset.
   - With INIT_HOLD=3 in a normal run, cache_init_no stays high for the 3 cycles following the last RST cycle.

Source files
------------

// File: rtl/fence_t_sequencer.sv
// Temporal-fence sequencer: halts commit, flushes N channels, waits for quiescence
// and timer padding, holds then staggers M microreset domains, supplies restart PC.
module fence_t_sequencer #(
    parameter int unsigned NUM_FLUSH   = 2,
    parameter int unsigned NUM_DOMAINS = 2,
    parameter int unsigned RST_CYCLES  = 16,
    parameter int unsigned INIT_HOLD   = 3,
    parameter int unsigned PAD_W       = 32,
    parameter int unsigned VLEN        = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   fence_t_i,
    input  logic [VLEN-1:0]        pc_commit_i,
    input  logic [VLEN-1:0]        boot_addr_i,
    output logic [VLEN-1:0]        rst_addr_o,
    input  logic                   pad_en_i,
    input  logic [PAD_W-1:0]       pad_cycles_i,
    input  logic                   time_irq_i,
    output logic [NUM_FLUSH-1:0]   flush_req_o,
    input  logic [NUM_FLUSH-1:0]   flush_ack_i,
    input  logic [NUM_FLUSH-1:0]   busy_i,
    output logic                   halt_o,
    output logic [NUM_DOMAINS-1:0] rst_uarch_no,
    output logic                   cache_init_no,
    output logic                   done_o
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] FLUSH   = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] RST     = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;

    localparam int unsigned CNT_MAX = (RST_CYCLES > NUM_DOMAINS) ? RST_CYCLES : NUM_DOMAINS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned INIT_W  = $clog2(INIT_HOLD + 1);

    localparam logic [CNT_W-1:0]  RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  REL_LAST = CNT_W'(NUM_DOMAINS - 1);
    localparam logic [INIT_W-1:0] INIT_VAL = INIT_W'(INIT_HOLD);

    logic [2:0]           state_q,     state_d;
    logic [NUM_FLUSH-1:0] flush_req_q, flush_req_d;
    logic [NUM_FLUSH-1:0] ack_seen_q,  ack_seen_d;
    logic [CNT_W-1:0]     rst_cnt_q,   rst_cnt_d;
    logic [PAD_W-1:0]     pad_cnt_q,   pad_cnt_d;
    logic [INIT_W-1:0]    init_cnt_q,  init_cnt_d;
    logic                 time_irq_q;
    logic                 done_q,      done_d;
    logic [VLEN-1:0]      rst_addr_q,  rst_addr_d;
    logic                 addr_vld_q,  addr_vld_d;

    logic [NUM_FLUSH-1:0] ack_hit;
    logic                 irq_rise;

    assign ack_hit  = flush_ack_i & flush_req_q;
    assign irq_rise = time_irq_i & ~time_irq_q;

    always_comb begin
        state_d     = state_q;
        flush_req_d = flush_req_q;
        ack_seen_d  = ack_seen_q;
        rst_cnt_d   = rst_cnt_q;
        done_d      = 1'b0;
        rst_addr_d  = rst_addr_q;
        addr_vld_d  = addr_vld_q;

        case (state_q)
            IDLE: begin
                if (fence_t_i) begin
                    state_d     = FLUSH;
                    rst_addr_d  = pc_commit_i + VLEN'(4);
                    addr_vld_d  = 1'b1;
                    flush_req_d = '1;
                    ack_seen_d  = '0;
                end
            end
            FLUSH: begin
                ack_seen_d  = ack_seen_q | ack_hit;
                flush_req_d = flush_req_q & ~ack_hit;
                if (&(ack_seen_q | ack_hit)) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if ((busy_i == '0) && (!pad_en_i || (pad_cnt_q == '0))) begin
                    state_d = RST;
                end
            end
            RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    rst_cnt_d = '0;
                    state_d   = RELEASE;
                end else begin
                    rst_cnt_d = rst_cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (rst_cnt_q == REL_LAST) begin
                    rst_cnt_d = '0;
                    state_d   = IDLE;
                    done_d    = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Timer-rising-edge load wins over the free-running decrement in every state.
    always_comb begin
        pad_cnt_d = pad_cnt_q;
        if (irq_rise) begin
            pad_cnt_d = pad_cycles_i;
        end else if (pad_cnt_q != '0) begin
            pad_cnt_d = pad_cnt_q - PAD_W'(1);
        end
    end

    always_comb begin
        init_cnt_d = init_cnt_q;
        if (state_q == RST) begin
            init_cnt_d = INIT_VAL;
        end else if (init_cnt_q != '0) begin
            init_cnt_d = init_cnt_q - INIT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            flush_req_q <= '0;
            ack_seen_q  <= '0;
            rst_cnt_q   <= '0;
            pad_cnt_q   <= '0;
            init_cnt_q  <= '0;
            time_irq_q  <= 1'b0;
            done_q      <= 1'b0;
            rst_addr_q  <= '0;
            addr_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_req_q <= flush_req_d;
            ack_seen_q  <= ack_seen_d;
            rst_cnt_q   <= rst_cnt_d;
            pad_cnt_q   <= pad_cnt_d;
            init_cnt_q  <= init_cnt_d;
            time_irq_q  <= time_irq_i;
            done_q      <= done_d;
            rst_addr_q  <= rst_addr_d;
            addr_vld_q  <= addr_vld_d;
        end
    end

    // Reset value of the restart address tracks boot_addr_i live, so a valid flag
    // selects between it and the captured PC instead of async-loading an input.
    assign rst_addr_o    = addr_vld_q ? rst_addr_q : boot_addr_i;
    assign flush_req_o   = flush_req_q;
    assign halt_o        = (state_q != IDLE);
    assign cache_init_no = (init_cnt_q != '0);
    assign done_o        = done_q;

    always_comb begin
        rst_uarch_no = '1;
        if (state_q == RST) begin
            rst_uarch_no = '0;
        end else if (state_q == RELEASE) begin
            for (int unsigned k = 0; k < NUM_DOMAINS; k++) begin
                rst_uarch_no[k] = (CNT_W'(k) <= rst_cnt_q);
            end
        end
    end

endmodule

// File: tb/tb_fence_t_sequencer.sv
// Scoreboard bench for fence_t_sequencer: stimulus pushes expected restart address
// and sequence length, a done_o monitor pops and compares; inline checks cover timing.
module tb_fence_t_sequencer;

    localparam int unsigned NF = 2;
    localparam int unsigned ND = 2;
    localparam int unsigned VL = 64;
    localparam int unsigned PW = 32;

    logic          clk;
    logic          rst_n;
    logic          fence_t;
    logic [VL-1:0] pc;
    logic [VL-1:0] boot;
    logic [VL-1:0] rst_addr;
    logic          pad_en;
    logic [PW-1:0] pad_cycles;
    logic          time_irq;
    logic [NF-1:0] req;
    logic [NF-1:0] ack;
    logic [NF-1:0] busy;
    logic          halt;
    logic [ND-1:0] uarch_n;
    logic          init_n;
    logic          done;

    typedef struct {
        logic [VL-1:0] addr;
        int unsigned   lat;
        int unsigned   t0;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    fence_t_sequencer #(
        .NUM_FLUSH(NF), .NUM_DOMAINS(ND), .RST_CYCLES(16), .INIT_HOLD(3), .PAD_W(PW), .VLEN(VL)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .fence_t_i(fence_t), .pc_commit_i(pc),
        .boot_addr_i(boot), .rst_addr_o(rst_addr), .pad_en_i(pad_en),
        .pad_cycles_i(pad_cycles), .time_irq_i(time_irq), .flush_req_o(req),
        .flush_ack_i(ack), .busy_i(busy), .halt_o(halt), .rst_uarch_no(uarch_n),
        .cache_init_no(init_n), .done_o(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Leaves the caller at the negedge of cycle 1 (first cycle with flush_req_o up).
    task automatic start(input logic [VL-1:0] p, input logic [VL-1:0] exp_addr, input int unsigned lat);
        exp_t e;
        tick();
        fence_t = 1'b1;
        pc      = p;
        e.addr  = exp_addr;
        e.lat   = lat;
        e.t0    = cyc + 1;
        sb.push_back(e);
        tick();
        fence_t = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned bound);
        int unsigned n = 0;
        while (halt && n < bound) begin
            tick();
            n++;
        end
        chk("idle_timeout", halt, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_unexpected: got done_o=1 expected no pending sequence (cyc %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_latency", 64'(cyc - e.t0), 64'(e.lat));
                chk("done_rst_addr", rst_addr, e.addr);
                chk("done_uarch_released", uarch_n, 2'b11);
                chk("done_halt_low", halt, 1'b0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; fence_t = 1'b0; pc = '0; boot = 64'h0000_0000_1000_0000;
        pad_en = 1'b0; pad_cycles = '0; time_irq = 1'b0; ack = '0; busy = '0;
        tick(); tick();
        chk("rst_req", req, 2'b00);
        chk("rst_halt", halt, 1'b0);
        chk("rst_uarch", uarch_n, 2'b11);
        chk("rst_init", init_n, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr", rst_addr, 64'h0000_0000_1000_0000);
        rst_n = 1'b1;
        tick(); tick();

        // 1: staggered acks, full sequence 5 FLUSH + 1 WAIT + 16 RST + 2 RELEASE
        start(64'h0000_0000_8000_0100, 64'h0000_0000_8000_0104, 24);
        chk("t1_req_c1", req, 2'b11);
        chk("t1_halt_c1", halt, 1'b1);
        tick(); chk("t1_req_c2", req, 2'b11);
        tick(); ack = 2'b01; chk("t1_req_c3", req, 2'b11);
        tick(); ack = 2'b00; chk("t1_req_c4", req, 2'b10);
        tick(); ack = 2'b10; chk("t1_req_c5", req, 2'b10);
        tick(); ack = 2'b00;
        chk("t1_req_c6", req, 2'b00);
        chk("t1_wait_uarch", uarch_n, 2'b11);
        chk("t1_wait_halt", halt, 1'b1);
        for (int i = 7; i <= 22; i++) begin
            tick();
            chk("t1_rst_uarch", uarch_n, 2'b00);
            chk("t1_rst_halt", halt, 1'b1);
            if (i == 8) chk("t1_rst_init", init_n, 1'b1);
        end
        tick(); chk("t1_rel0_uarch", uarch_n, 2'b01); chk("t1_rel0_init", init_n, 1'b1);
        tick(); chk("t1_rel1_uarch", uarch_n, 2'b11); chk("t1_rel1_halt", halt, 1'b1);
        chk("t1_rel1_init", init_n, 1'b1);
        tick(); chk("t1_idle_halt", halt, 1'b0); chk("t1_idle_init", init_n, 1'b1);
        tick(); chk("t1_init_expired", init_n, 1'b0); chk("t1_done_one_cycle", done, 1'b0);

        // 2: both acks in first request cycle, PC wraps modulo 2^64
        start(64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0002, 20);
        ack = 2'b11;
        tick(); ack = 2'b00;
        chk("t2_wait_req", req, 2'b00);
        chk("t2_wait_uarch", uarch_n, 2'b11);
        tick(); chk("t2_rst_uarch", uarch_n, 2'b00);
        wait_idle(40); tick();

        // 3: padding 10 loaded two cycles before fence -> 8 WAIT cycles
        pad_en = 1'b1; pad_cycles = 32'd10;
        tick(); time_irq = 1'b1;
        tick();
        start(64'h0000_0000_0000_2000, 64'h0000_0000_0000_2004, 27);
        ack = 2'b11;
        tick(); ack = 2'b00;
        for (int i = 3; i <= 9; i++) begin
            tick();
            chk("t3_pad_wait_uarch", uarch_n, 2'b11);
        end
        tick(); chk("t3_pad_rst_uarch", uarch_n, 2'b00);
        wait_idle(60);
        time_irq = 1'b0;
        tick(); tick();

        // 3b: same padding but pad_en_i=0 -> RST right after one WAIT cycle
        pad_en = 1'b0;
        tick(); time_irq = 1'b1;
        tick();
        start(64'h0000_0000_0000_3000, 64'h0000_0000_0000_3004, 20);
        ack = 2'b11;
        tick(); ack = 2'b00;
        tick(); chk("t3b_nopad_rst_uarch", uarch_n, 2'b00);
        wait_idle(40);
        time_irq = 1'b0;
        tick();

        // 4: busy_i[1] held for 20 WAIT cycles
        start(64'h0000_0000_0000_4000, 64'h0000_0000_0000_4004, 40);
        ack = 2'b11; busy = 2'b10;
        for (int i = 2; i <= 21; i++) begin
            tick();
            if (i == 2) ack = 2'b00;
            chk("t4_busy_uarch", uarch_n, 2'b11);
            chk("t4_busy_halt", halt, 1'b1);
        end
        tick(); busy = 2'b00; chk("t4_last_wait_uarch", uarch_n, 2'b11);
        tick(); chk("t4_rst_uarch", uarch_n, 2'b00);
        wait_idle(60); tick();

        // 5: spurious acks in IDLE, second fence during RST ignored
        ack = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_idle_halt", halt, 1'b0);
            chk("t5_idle_req", req, 2'b00);
            chk("t5_idle_addr", rst_addr, 64'h0000_0000_0000_4004);
        end
        ack = 2'b00;
        start(64'h0000_0000_0000_5000, 64'h0000_0000_0000_5004, 20);
        ack = 2'b11;
        tick(); ack = 2'b00;
        tick(); tick(); tick();
        fence_t = 1'b1; pc = 64'h0000_0000_DEAD_0000;
        tick(); fence_t = 1'b0; pc = '0;
        chk("t5_rst_uarch", uarch_n, 2'b00);
        chk("t5_rst_addr_kept", rst_addr, 64'h0000_0000_0000_5004);
        wait_idle(40);
        tick(); tick();
        chk("t5_no_restart", halt, 1'b0);
        chk("t5_addr_final", rst_addr, 64'h0000_0000_0000_5004);

        // 6: async reset in the 5th RST cycle, then a clean sequence
        start(64'h0000_0000_0000_6000, 64'h0000_0000_0000_6004, 20);
        ack = 2'b11;
        tick(); ack = 2'b00;
        for (int i = 3; i <= 7; i++) tick();
        chk("t6_pre_init", init_n, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_abort_uarch", uarch_n, 2'b11);
        chk("t6_abort_halt", halt, 1'b0);
        chk("t6_abort_req", req, 2'b00);
        chk("t6_abort_addr", rst_addr, 64'h0000_0000_1000_0000);
        chk("t6_abort_init", init_n, 1'b0);
        sb.delete();
        tick(); rst_n = 1'b1;
        tick();
        chk("t6_post_init", init_n, 1'b0);
        chk("t6_post_halt", halt, 1'b0);
        start(64'h0000_0000_0000_7000, 64'h0000_0000_0000_7004, 20);
        ack = 2'b11;
        tick(); ack = 2'b00;
        wait_idle(40);
        tick(); tick();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
